// File: rtl/full_handshake_rx_pkg.sv
// =============================================================================
// Module      : full_handshake_rx_pkg
// Description : Shared handshake definitions (state encodings, sync depth).
//               FULL_HANDSHAKE_RX_SYNC3_EN selects a 3-flop request synchroniser.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package full_handshake_rx_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'b01,
        STATE_ACK  = 2'b10
    } state_t;

`ifdef FULL_HANDSHAKE_RX_SYNC3_EN
    localparam int c_SYNC_DEPTH = 3;
`else
    localparam int c_SYNC_DEPTH = 2;
`endif

endpackage

`default_nettype wire

// File: rtl/full_handshake_rx_sync_ff.sv
// =============================================================================
// Module      : sync_ff
// Description : N-flop single-bit synchroniser with async active-low reset.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/full_handshake_rx.sv
// =============================================================================
// Module      : full_handshake_rx
// Description : RX side of a four-phase CDC handshake with valid/ready output.
//               FULL_HANDSHAKE_RX_SYNC3_EN adds a third request sync flop.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module full_handshake_rx
    import full_handshake_rx_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic [DW-1:0] req_data_i,
    output logic          ack_o,
    output logic          recv_valid_o,
    output logic [DW-1:0] recv_data_o,
    input  logic          recv_ready_i
);

    logic          w_req_s;
    logic          w_free;
    logic          w_capture;
    logic          w_ack_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ack;
    logic          r_valid;
    logic [DW-1:0] r_data;

    sync_ff #(
        .STAGES (c_SYNC_DEPTH)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (req_i),
        .q_o   (w_req_s)
    );

    // The holding register may be refilled on the same edge the consumer drains it.
    assign w_free = !r_valid || recv_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_capture   = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                w_ack_nxt = 1'b0;
                if (w_req_s && w_free) begin
                    w_state_nxt = STATE_ACK;
                    w_ack_nxt   = 1'b1;
                    w_capture   = 1'b1;
                end
            end
            STATE_ACK: begin
                w_ack_nxt = 1'b1;
                if (!w_req_s) begin
                    w_state_nxt = STATE_IDLE;
                    w_ack_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = STATE_IDLE;
                w_ack_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STATE_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // req_data_i is stable by protocol whenever the synchronised request is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_data  <= req_data_i;
        end else if (r_valid && recv_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign ack_o        = r_ack;
    assign recv_valid_o = r_valid;
    assign recv_data_o  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_full_handshake_rx.sv
// =============================================================================
// Module      : tb_full_handshake_rx
// Description : Self-checking bench for full_handshake_rx (both sync depths).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_full_handshake_rx;

    localparam int DW = 32;
`ifdef FULL_HANDSHAKE_RX_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_i = 1'b0;
    logic [DW-1:0] req_data_i = '0;
    logic          ack_o;
    logic          recv_valid_o;
    logic [DW-1:0] recv_data_o;
    logic          recv_ready_i = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic          cons_en = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held_data = '0;
    int            ack_rises = 0;
    int            valid_rises = 0;
    logic          ack_prev = 1'b0;
    logic          valid_prev = 1'b0;

    full_handshake_rx #(.DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .req_data_i   (req_data_i),
        .ack_o        (ack_o),
        .recv_valid_o (recv_valid_o),
        .recv_data_o  (recv_data_o),
        .recv_ready_i (recv_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string tag);
        int n = 0;
        while (ack_o !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, ack_o}, {31'd0, v});
    endtask

    task automatic tx_transfer(input logic [DW-1:0] d);
        @(negedge clk);
        req_i      = 1'b1;
        req_data_i = d;
        exp_q.push_back(d);
        wait_ack(1'b1, "tx_ack_rise");
        @(negedge clk);
        req_i = 1'b0;
        wait_ack(1'b0, "tx_ack_fall");
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    // Random consumer; the ready driven here applies at the following posedge.
    always @(negedge clk) begin
        if (cons_en) begin
            if (stall_prev) begin
                check("hold_valid", {31'd0, recv_valid_o}, 32'd1);
                check("hold_data", recv_data_o, held_data);
            end
            recv_ready_i = 1'($urandom_range(0, 1));
            if (recv_valid_o && recv_ready_i) got_q.push_back(recv_data_o);
            stall_prev = recv_valid_o && !recv_ready_i;
            held_data  = recv_data_o;
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (ack_o && !ack_prev) ack_rises++;
        if (recv_valid_o && !valid_prev) valid_rises++;
        ack_prev   = ack_o;
        valid_prev = recv_valid_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int v0;
        logic [DW-1:0] d;

        // Reset state
        #2;
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_valid", {31'd0, recv_valid_o}, 32'd0);
        check("rst_data", recv_data_o, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic transfer and latency
        recv_ready_i = 1'b1;
        req_i        = 1'b1;
        req_data_i   = 32'hDEADBEEF;
        edges(LAT - 1);
        check("t1_ack_early", {31'd0, ack_o}, 32'd0);
        check("t1_valid_early", {31'd0, recv_valid_o}, 32'd0);
        edges(1);
        check("t1_ack", {31'd0, ack_o}, 32'd1);
        check("t1_valid", {31'd0, recv_valid_o}, 32'd1);
        check("t1_data", recv_data_o, 32'hDEADBEEF);
        edges(1);
        check("t1_valid_drop", {31'd0, recv_valid_o}, 32'd0);
        check("t1_ack_hold", {31'd0, ack_o}, 32'd1);
        @(negedge clk);
        req_i = 1'b0;
        edges(LAT - 1);
        check("t1_ack_fall_early", {31'd0, ack_o}, 32'd1);
        edges(1);
        check("t1_ack_fall", {31'd0, ack_o}, 32'd0);

        // Backpressure
        @(negedge clk);
        recv_ready_i = 1'b0;
        req_i        = 1'b1;
        req_data_i   = 32'h11111111;
        edges(LAT);
        check("t2_ack1", {31'd0, ack_o}, 32'd1);
        check("t2_data1", recv_data_o, 32'h11111111);
        @(negedge clk);
        req_i = 1'b0;
        wait_ack(1'b0, "t2_ack1_fall");
        @(negedge clk);
        req_i      = 1'b1;
        req_data_i = 32'h22222222;
        edges(LAT + 4);
        check("t2_ack_blocked", {31'd0, ack_o}, 32'd0);
        check("t2_data_held", recv_data_o, 32'h11111111);
        check("t2_valid_held", {31'd0, recv_valid_o}, 32'd1);
        @(negedge clk);
        recv_ready_i = 1'b1;
        edges(1);
        check("t2_ack2", {31'd0, ack_o}, 32'd1);
        check("t2_data2", recv_data_o, 32'h22222222);
        check("t2_no_gap", {31'd0, recv_valid_o}, 32'd1);
        @(negedge clk);
        req_i = 1'b0;
        wait_ack(1'b0, "t2_ack2_fall");

        // Back-to-back, incrementing then random data, random consumer
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        cons_en = 1'b1;
        for (int i = 0; i < 16; i++) tx_transfer(DW'(i));
        for (int i = 0; i < 20; i++) tx_transfer(DW'($urandom));
        for (int n = 0; n < 100 && got_q.size() < exp_q.size(); n++) @(negedge clk);
        cons_en = 1'b0;
        check("t3_count", DW'(got_q.size()), DW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("t3_word", got_q[i], exp_q[i]);
        @(negedge clk);
        recv_ready_i = 1'b1;
        repeat (2) @(negedge clk);

        // Glitch between edges, then a held request
        a0 = ack_rises;
        v0 = valid_rises;
        @(posedge clk);
        #2 req_i = 1'b1;
        req_data_i = 32'hBADBAD00;
        #2 req_i = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("t4_glitch_ignored", DW'(ack_rises - a0), 32'd0);
        d          = 32'hCAFEF00D;
        req_i      = 1'b1;
        req_data_i = d;
        wait_ack(1'b1, "t4_ack_rise");
        @(negedge clk);
        req_i = 1'b0;
        wait_ack(1'b0, "t4_ack_fall");
        repeat (4) @(negedge clk);
        check("t4_ack_once", DW'(ack_rises - a0), 32'd1);
        check("t4_capture_once", DW'(valid_rises - v0), 32'd1);
        check("t4_data", recv_data_o, d);

        // Reset mid-transfer
        @(negedge clk);
        recv_ready_i = 1'b0;
        req_i        = 1'b1;
        req_data_i   = 32'hA5A5A5A5;
        edges(LAT);
        check("t5_ack_pre", {31'd0, ack_o}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_ack", {31'd0, ack_o}, 32'd0);
        check("t5_rst_valid", {31'd0, recv_valid_o}, 32'd0);
        check("t5_rst_data", recv_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edges(LAT - 1);
        check("t5_ack_early", {31'd0, ack_o}, 32'd0);
        edges(1);
        check("t5_ack", {31'd0, ack_o}, 32'd1);
        check("t5_valid", {31'd0, recv_valid_o}, 32'd1);
        check("t5_data", recv_data_o, 32'hA5A5A5A5);
        @(negedge clk);
        req_i        = 1'b0;
        recv_ready_i = 1'b1;
        wait_ack(1'b0, "t5_ack_fall");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
